demux1_2x2_reg: RTL

Registered 1-to-2 demultiplexer for WIDTH-bit buses: the inverse of the 2:1 bus mux. A single valid/ready input stream is steered by a select bit into one of two one-entry output registers. Each output has its own valid/ready handshake. Each destination keeps a wrapping count of the transfers it has accepted. The block sits between a producer stage and two consumer stages in the datapath, for example ALU result routing to two writeback paths, where each consumer can independently stall.

---
 rtl/demux1_2x2_reg_if.sv | 25 ++
 rtl/demux1_2x2_reg.sv | 73 +++++++
 2 files changed

// File: rtl/demux1_2x2_reg_if.sv
// Producer/consumer bundle for the registered 1-to-2 demultiplexer.
// The block uses the slave view; whoever drives it uses the master view.
interface demux1_2x2_reg_if #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0]      in_data;
  logic                  in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0][WIDTH-1:0] out_data;
  logic [1:0]            out_valid;
  logic [1:0]            out_ready;
  logic [1:0][CNT_W-1:0] count;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/demux1_2x2_reg.sv
// Steers one valid/ready stream into two one-entry output slots,
// each with its own handshake and a wrapping accept counter.
module demux1_2x2_reg #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              reset_n,
  demux1_2x2_reg_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  slot_state_e           state     [2];
  slot_state_e           state_nxt [2];
  logic [1:0][WIDTH-1:0] data_q, data_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            full;
  logic [1:0]            load;
  logic [1:0]            drain;
  logic                  ready;
  logic                  accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= '{default: EMPTY};
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      full[i] = (state[i] == FULL);
    end
  end

  // Readiness looks only at the targeted slot so a stalled consumer never blocks the other path.
  always_comb begin
    ready  = !full[bus.in_sel] || bus.out_ready[bus.in_sel];
    accept = bus.in_valid && ready;
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      load[i]      = accept && (bus.in_sel == i[0]);
      drain[i]     = full[i] && bus.out_ready[i];
      state_nxt[i] = state[i];
      data_d[i]    = data_q[i];
      cnt_d[i]     = cnt_q[i];
      // A load wins over a drain on the same edge: the slot stays full with the new payload.
      if (load[i]) begin
        state_nxt[i] = FULL;
        data_d[i]    = bus.in_data;
        cnt_d[i]     = cnt_q[i] + 1'b1;
      end else if (drain[i]) begin
        state_nxt[i] = EMPTY;
      end
    end
  end

  always_comb begin
    bus.in_ready  = ready;
    bus.out_valid = full;
    bus.out_data  = data_q;
    bus.count     = cnt_q;
  end

endmodule
